// File: rtl/qsfpp_link_sequencer.sv
// Reset/bring-up sequencer for the QSFP+ 40G PHY: orders PHY, TX and RX resets and retries RX on timeout or link loss.
// Define QSFPP_LINK_SEQ_ESCALATE_EN to turn MAX_RX_RETRIES consecutive RX timeouts into a full PHY restart.
module qsfpp_link_sequencer #(
  parameter int unsigned PHY_RST_CYCLES     = 1000,
  parameter int unsigned TX_HOLD_CYCLES     = 100000000,
  parameter int unsigned RX_RST_CYCLES      = 5000,
  parameter int unsigned RX_TIMEOUT_CYCLES  = 50000000,
  parameter int unsigned UP_DEBOUNCE_CYCLES = 1000,
  parameter int unsigned MAX_RX_RETRIES     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_lock,
  input  logic        link_up,
  input  logic        sw_phy_reset,
  input  logic        sw_tx_reset,
  input  logic        sw_rx_reset,
  output logic        phy_sys_rst,
  output logic        tx_datapath_rst,
  output logic        rx_datapath_rst,
  output logic        link_ready,
  output logic [2:0]  state,
  output logic [7:0]  retry_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    PHY_RST = 3'd0,
    TX_HOLD = 3'd1,
    RX_RST  = 3'd2,
    RX_WAIT = 3'd3,
    LINK_UP = 3'd4
  } state_t;

`ifdef QSFPP_LINK_SEQ_ESCALATE_EN
  localparam bit ESCALATE = 1'b1;
`else
  localparam bit ESCALATE = 1'b0;
`endif

  state_t      cur, nxt;
  logic        enter;
  logic [31:0] cnt, cnt_n, up_cnt, up_cnt_n;
  logic [7:0]  retry_n;
  logic [15:0] drop_n;
  logic [8:0]  retry_inc;

  // Down-counter preload so each state lasts exactly its parameter in cycles.
  function automatic logic [31:0] load_val(input state_t s);
    case (s)
      PHY_RST: load_val = PHY_RST_CYCLES - 32'd1;
      TX_HOLD: load_val = TX_HOLD_CYCLES - 32'd1;
      RX_RST:  load_val = RX_RST_CYCLES - 32'd1;
      RX_WAIT: load_val = RX_TIMEOUT_CYCLES - 32'd1;
      default: load_val = '0;
    endcase
  endfunction

  always_comb begin
    nxt       = cur;
    enter     = 1'b0;
    cnt_n     = cnt;
    up_cnt_n  = '0;
    retry_n   = retry_cnt;
    drop_n    = drop_cnt;
    retry_inc = {1'b0, retry_cnt} + 9'd1;
    if (!pll_lock || sw_phy_reset) begin
      nxt = PHY_RST; enter = 1'b1;
    end else if (sw_tx_reset) begin
      nxt = TX_HOLD; enter = 1'b1;
    end else if (sw_rx_reset) begin
      nxt = RX_RST; enter = 1'b1;
    end else begin
      case (cur)
        PHY_RST: if (cnt == '0) begin nxt = TX_HOLD; enter = 1'b1; end
        TX_HOLD: if (cnt == '0) begin nxt = RX_RST;  enter = 1'b1; end
        RX_RST:  if (cnt == '0) begin nxt = RX_WAIT; enter = 1'b1; end
        RX_WAIT: begin
          // Debounce completion beats a simultaneous timeout.
          if (link_up && up_cnt == UP_DEBOUNCE_CYCLES - 32'd1) begin
            nxt = LINK_UP; enter = 1'b1;
          end else if (cnt == '0) begin
            enter = 1'b1;
            if (ESCALATE && {23'd0, retry_inc} >= MAX_RX_RETRIES) begin
              nxt = PHY_RST; retry_n = '0;
            end else begin
              nxt = RX_RST;
              retry_n = retry_inc[8] ? 8'hFF : retry_inc[7:0];
            end
          end
        end
        LINK_UP: if (!link_up) begin
          nxt = RX_RST; enter = 1'b1;
          drop_n = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
        end
        default: begin nxt = PHY_RST; enter = 1'b1; end
      endcase
    end
    if (enter && nxt == LINK_UP) retry_n = '0;
    if (enter) begin
      cnt_n    = load_val(nxt);
      up_cnt_n = '0;
    end else begin
      cnt_n    = (cnt == '0) ? cnt : cnt - 32'd1;
      up_cnt_n = (cur == RX_WAIT && link_up) ? up_cnt + 32'd1 : '0;
    end
  end

  // Outputs decode the next state so they move on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur             <= PHY_RST;
      cnt             <= load_val(PHY_RST);
      up_cnt          <= '0;
      retry_cnt       <= '0;
      drop_cnt        <= '0;
      phy_sys_rst     <= 1'b1;
      tx_datapath_rst <= 1'b1;
      rx_datapath_rst <= 1'b1;
      link_ready      <= 1'b0;
    end else begin
      cur             <= nxt;
      cnt             <= cnt_n;
      up_cnt          <= up_cnt_n;
      retry_cnt       <= retry_n;
      drop_cnt        <= drop_n;
      phy_sys_rst     <= (nxt == PHY_RST);
      tx_datapath_rst <= (nxt == PHY_RST) || (nxt == TX_HOLD);
      rx_datapath_rst <= (nxt == PHY_RST) || (nxt == TX_HOLD) || (nxt == RX_RST);
      link_ready      <= (nxt == LINK_UP);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_qsfpp_link_sequencer.sv
// Scoreboard bench for qsfpp_link_sequencer: phase/age reference model feeds a queue, negedge monitor compares.
module tb_qsfpp_link_sequencer;
  localparam int P_PHY = 4, P_TX = 8, P_RX = 3, P_TO = 20, P_DEB = 5, P_MAX = 2;
`ifdef QSFPP_LINK_SEQ_ESCALATE_EN
  localparam bit ESC = 1'b1;
`else
  localparam bit ESC = 1'b0;
`endif

  logic clk, rst, pll_lock, link_up, sw_phy_reset, sw_tx_reset, sw_rx_reset;
  logic phy_sys_rst, tx_datapath_rst, rx_datapath_rst, link_ready;
  logic [2:0] state;
  logic [7:0] retry_cnt;
  logic [15:0] drop_cnt;

  qsfpp_link_sequencer #(
    .PHY_RST_CYCLES(P_PHY), .TX_HOLD_CYCLES(P_TX), .RX_RST_CYCLES(P_RX),
    .RX_TIMEOUT_CYCLES(P_TO), .UP_DEBOUNCE_CYCLES(P_DEB), .MAX_RX_RETRIES(P_MAX)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .link_up(link_up),
    .sw_phy_reset(sw_phy_reset), .sw_tx_reset(sw_tx_reset), .sw_rx_reset(sw_rx_reset),
    .phy_sys_rst(phy_sys_rst), .tx_datapath_rst(tx_datapath_rst),
    .rx_datapath_rst(rx_datapath_rst), .link_ready(link_ready),
    .state(state), .retry_cnt(retry_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st; logic phy, tx, rx, rdy; logic [7:0] rc; logic [15:0] dc;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, ncyc = 0;

  // Reference model: phase, cycles already spent in it, consecutive sampled link_up highs.
  int m_phase = 0, m_age = 0, m_ups = 0, m_retries = 0, m_drops = 0;

  function automatic int dur(input int p);
    case (p)
      0: return P_PHY;
      1: return P_TX;
      2: return P_RX;
      default: return P_TO;
    endcase
  endfunction

  task automatic go(input int p);
    m_phase = p; m_age = 0; m_ups = 0;
    if (p == 4) m_retries = 0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    ncyc++;
    if (rst) begin
      go(0); m_retries = 0; m_drops = 0;
    end else if (!pll_lock || sw_phy_reset) go(0);
    else if (sw_tx_reset) go(1);
    else if (sw_rx_reset) go(2);
    else if (m_phase <= 2) begin
      if (m_age + 1 >= dur(m_phase)) go(m_phase + 1); else m_age++;
    end else if (m_phase == 3) begin
      m_ups = link_up ? m_ups + 1 : 0;
      if (m_ups >= P_DEB) go(4);
      else if (m_age + 1 >= P_TO) begin
        if (m_retries < 255) m_retries++;
        if (ESC && m_retries >= P_MAX) begin m_retries = 0; go(0); end
        else go(2);
      end else m_age++;
    end else if (!link_up) begin
      if (m_drops < 65535) m_drops++;
      go(2);
    end
    e.st  = 3'(m_phase);
    e.phy = (m_phase == 0);
    e.tx  = (m_phase <= 1);
    e.rx  = (m_phase <= 2);
    e.rdy = (m_phase == 4);
    e.rc  = 8'(m_retries);
    e.dc  = 16'(m_drops);
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {state, phy_sys_rst, tx_datapath_rst, rx_datapath_rst, link_ready, retry_cnt, drop_cnt};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs cyc=%0d got st=%0d phy=%b tx=%b rx=%b rdy=%b rc=%0d dc=%0d want st=%0d phy=%b tx=%b rx=%b rdy=%b rc=%0d dc=%0d",
                 ncyc, a.st, a.phy, a.tx, a.rx, a.rdy, a.rc, a.dc, e.st, e.phy, e.tx, e.rx, e.rdy, e.rc, e.dc);
      end
    end
  end

  task automatic cyc(input bit r, input bit p, input bit u, input bit sp, input bit st, input bit sr);
    @(negedge clk);
    rst = r; pll_lock = p; link_up = u; sw_phy_reset = sp; sw_tx_reset = st; sw_rx_reset = sr;
  endtask

  task automatic run(input int n, input bit p, input bit u);
    for (int i = 0; i < n; i++) cyc(1'b0, p, u, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Holds link_up low until the model is in its first RX_WAIT cycle, with that cycle already driven low.
  task automatic wait_rx_wait();
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      rst = 1'b0; pll_lock = 1'b1; link_up = 1'b0;
      sw_phy_reset = 1'b0; sw_tx_reset = 1'b0; sw_rx_reset = 1'b0;
      if (m_phase == 3 && m_age == 0) found = 1'b1;
    end
    if (!found) begin
      tests++; fails++;
      $display("FAIL wait_rx_wait got phase=%0d want phase=3 within 200 cycles", m_phase);
    end
  endtask

  task automatic rand_run(input int n, input int pll_pct, input int up_pct, input int sw_pct);
    for (int i = 0; i < n; i++)
      cyc(1'b0, int'($urandom_range(99)) < pll_pct, int'($urandom_range(99)) < up_pct,
          int'($urandom_range(999)) < sw_pct, int'($urandom_range(999)) < sw_pct,
          int'($urandom_range(999)) < sw_pct);
  endtask

  initial begin
    rst = 1'b1; pll_lock = 1'b1; link_up = 1'b0;
    sw_phy_reset = 1'b0; sw_tx_reset = 1'b0; sw_rx_reset = 1'b0;
    // clean bring-up, link drop, software priority, pll loss together with software requests
    do_rst();
    run(40, 1'b1, 1'b1);
    run(1, 1'b1, 1'b0);
    run(30, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    run(40, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run(40, 1'b1, 1'b1);
    // held software requests
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run(20, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    run(30, 1'b1, 1'b1);
    // late pll lock
    do_rst();
    run(10, 1'b0, 1'b0);
    run(40, 1'b1, 1'b1);
    // timeouts and escalation
    run(100, 1'b1, 1'b0);
    // debounce completing on the timeout cycle
    wait_rx_wait();
    run(14, 1'b1, 1'b0);
    run(15, 1'b1, 1'b1);
    // debounce glitch
    wait_rx_wait();
    run(4, 1'b1, 1'b1);
    run(1, 1'b1, 1'b0);
    run(12, 1'b1, 1'b1);
    // randomized profiles
    for (int s = 0; s < 40; s++)
      rand_run(int'($urandom_range(400, 100)), 95 + int'($urandom_range(5)),
               70 + int'($urandom_range(30)), int'($urandom_range(8)));
    // retry counter saturation
    do_rst();
    run(6500, 1'b1, 1'b0);
    run(40, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
